// File: rtl/cmlk_ingress_pkg.sv
// Shared definitions for the camera-link frame ingress: FSM encoding and
// per-line / per-frame beat count derivation.
package cmlk_ingress_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ingress_state_t;

  function automatic int calc_bpl(input int img_w, input int pix_w, input int data_w);
    return (img_w * pix_w) / data_w;
  endfunction

  function automatic int calc_bpf(input int img_w, input int pix_w, input int data_w,
                                  input int img_h);
    return calc_bpl(img_w, pix_w, data_w) * img_h;
  endfunction

endpackage

// File: rtl/cmlk_skid_buf.sv
// Two-entry output buffer with a registered in_rdy, so nothing on the output
// side reaches the input-side ready combinationally.
module cmlk_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_vld,
  output logic         in_rdy,
  output logic [W-1:0] out_data,
  output logic         out_vld,
  input  logic         out_rdy
);

  logic [W-1:0] ent0, ent1;
  logic [1:0]   cnt, cnt_nxt;
  logic         rdy_q;
  logic         push, pop;

  assign push     = in_vld & rdy_q;
  assign pop      = (cnt != 2'd0) & out_rdy;
  assign cnt_nxt  = cnt + 2'(push) - 2'(pop);
  assign in_rdy   = rdy_q;
  assign out_vld  = (cnt != 2'd0);
  assign out_data = ent0;

  // ent0 is always the head; it only moves on a pop or when filling an empty slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0  <= '0;
      ent1  <= '0;
      cnt   <= 2'd0;
      rdy_q <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      rdy_q <= (cnt_nxt < 2'd2);
      if (push && ((cnt == 2'd0) || ((cnt == 2'd1) && pop)))
        ent0 <= in_data;
      else if (pop)
        ent0 <= ent1;
      if (push && (((cnt == 2'd1) && !pop) || ((cnt == 2'd2) && pop)))
        ent1 <= in_data;
    end
  end

endmodule

// File: rtl/cmlk_frame_ingress.sv
// Frame ingress: tracks line/column position of an AXI-stream video feed,
// flags framing errors and forwards in-frame beats with sol/eol markers.
// Optional macro CMLK_TLAST_RESYNC_EN: an early tlast closes the current line.
// Handshakes: a beat moves when valid and ready are both high on a rising edge.
module cmlk_frame_ingress
  import cmlk_ingress_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 2048,
  parameter int IMG_H  = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_cmlk_tdata,
  input  logic              s_axis_cmlk_tvalid,
  output logic              s_axis_cmlk_tready,
  input  logic              s_axis_cmlk_tlast,
  input  logic              s_axis_cmlk_tuser,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic              dout_sol,
  output logic              dout_eol,
  input  logic [1:0]        frame_type_i,
  output logic              frame_start,
  output logic [1:0]        frame_type_o,
  output logic [15:0]       frame_cnt,
  output logic              unexpected_data,
  output logic              unexpected_tlast,
  output logic              missing_data,
  output logic              dbg_state
);

  localparam int BPL    = calc_bpl(IMG_W, PIX_W, DATA_W);
  localparam int COL_W  = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int LINE_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(BPL - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(IMG_H - 1);

  ingress_state_t    state, state_nxt;
  logic [COL_W-1:0]  col, eff_col;
  logic [LINE_W-1:0] line, eff_line;
  logic accept, in_frame, last_col, wrap, frame_done, fwd;
  logic fs_nxt, md_nxt, ud_nxt, ut_nxt;

  logic [DATA_W-1:0] stage_data;
  logic              stage_vld, stage_sol, stage_eol;
  logic              skid_in_rdy;

  assign accept             = s_axis_cmlk_tvalid & skid_in_rdy;
  assign s_axis_cmlk_tready = skid_in_rdy;
  assign dbg_state          = state;

  // A start-of-frame beat is column 0 of line 0 regardless of where we were
  always_comb begin
    in_frame   = s_axis_cmlk_tuser | (state == ST_ACTIVE);
    eff_col    = s_axis_cmlk_tuser ? '0 : col;
    eff_line   = s_axis_cmlk_tuser ? '0 : line;
    last_col   = (eff_col == COL_LAST);
`ifdef CMLK_TLAST_RESYNC_EN
    wrap       = last_col | s_axis_cmlk_tlast;
`else
    wrap       = last_col;
`endif
    fwd        = accept & in_frame;
    frame_done = fwd & wrap & (eff_line == LINE_LAST);
    fs_nxt     = accept & s_axis_cmlk_tuser;
    md_nxt     = fs_nxt & (state == ST_ACTIVE);
    ud_nxt     = accept & ~in_frame;
    ut_nxt     = fwd & (s_axis_cmlk_tlast != last_col);
  end

  always_comb begin
    state_nxt = state;
    if (fs_nxt)
      state_nxt = ST_ACTIVE;
    if (frame_done)
      state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col              <= '0;
      line             <= '0;
      frame_cnt        <= '0;
      frame_type_o     <= '0;
      frame_start      <= 1'b0;
      missing_data     <= 1'b0;
      unexpected_data  <= 1'b0;
      unexpected_tlast <= 1'b0;
      stage_vld        <= 1'b0;
      stage_data       <= '0;
      stage_sol        <= 1'b0;
      stage_eol        <= 1'b0;
    end else begin
      frame_start      <= fs_nxt;
      missing_data     <= md_nxt;
      unexpected_data  <= ud_nxt;
      unexpected_tlast <= ut_nxt;
      if (fs_nxt)
        frame_type_o <= frame_type_i;
      if (frame_done)
        frame_cnt <= frame_cnt + 16'd1;
      if (fwd) begin
        if (wrap) begin
          col  <= '0;
          line <= (eff_line == LINE_LAST) ? '0 : eff_line + LINE_W'(1);
        end else begin
          col  <= eff_col + COL_W'(1);
          line <= eff_line;
        end
      end
      // Stage drains into the buffer whenever the buffer can take it
      if (fwd) begin
        stage_vld  <= 1'b1;
        stage_data <= s_axis_cmlk_tdata;
        stage_sol  <= (eff_col == '0);
        stage_eol  <= last_col;
      end else if (skid_in_rdy) begin
        stage_vld  <= 1'b0;
      end
    end
  end

  cmlk_skid_buf #(.W(DATA_W + 2)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  ({stage_data, stage_sol, stage_eol}),
    .in_vld   (stage_vld),
    .in_rdy   (skid_in_rdy),
    .out_data ({dout, dout_sol, dout_eol}),
    .out_vld  (dout_vld),
    .out_rdy  (dout_rdy)
  );

endmodule

// File: tb/tb_cmlk_frame_ingress.sv
// Self-checking bench for cmlk_frame_ingress (64-bit beats, 8 beats/line, 4 lines).
// Follows CMLK_TLAST_RESYNC_EN when defined for the build.
module tb_cmlk_frame_ingress;

  localparam int DATA_W = 64;
  localparam int PIX_W  = 8;
  localparam int IMG_W  = 64;
  localparam int IMG_H  = 4;
  localparam int BPL    = 8;
  localparam int EW     = DATA_W + 2;
`ifdef CMLK_TLAST_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] tdata;
  logic              tvalid, tready, tlast, tuser;
  logic [DATA_W-1:0] dout;
  logic              dout_vld, dout_rdy, dout_sol, dout_eol;
  logic [1:0]        frame_type_i, frame_type_o;
  logic              frame_start, unexpected_data, unexpected_tlast, missing_data;
  logic [15:0]       frame_cnt;
  logic              dbg_state;

  cmlk_frame_ingress #(.DATA_W(DATA_W), .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_axis_cmlk_tdata  (tdata),
    .s_axis_cmlk_tvalid (tvalid),
    .s_axis_cmlk_tready (tready),
    .s_axis_cmlk_tlast  (tlast),
    .s_axis_cmlk_tuser  (tuser),
    .dout               (dout),
    .dout_vld           (dout_vld),
    .dout_rdy           (dout_rdy),
    .dout_sol           (dout_sol),
    .dout_eol           (dout_eol),
    .frame_type_i       (frame_type_i),
    .frame_start        (frame_start),
    .frame_type_o       (frame_type_o),
    .frame_cnt          (frame_cnt),
    .unexpected_data    (unexpected_data),
    .unexpected_tlast   (unexpected_tlast),
    .missing_data       (missing_data),
    .dbg_state          (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            cyc = 0;
  bit            m_active;
  int            m_col, m_line;
  logic [15:0]   m_fcnt;
  logic [1:0]    m_type;
  logic [3:0]    exp_pulse;
  int            fs_seen = 0, md_seen = 0, ud_seen = 0, ut_seen = 0, out_cnt = 0;
  bit            chk_lat = 1'b0;
  int            watch_idx = -1;
  logic          watch_sol;
  bit            prev_stall;
  logic [EW-1:0] prev_beat;
  int            low_run;
  bit            rdy_toggle = 1'b0;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    int a;
    bit sol, eol;
    cyc++;
    if (!rst_n) begin
      m_active = 1'b0; m_col = 0; m_line = 0; m_fcnt = '0; m_type = '0;
      exp_q.delete(); acc_q.delete();
      exp_pulse = '0; prev_stall = 1'b0; low_run = 0;
    end else begin
      chk("pulses", {frame_start, missing_data, unexpected_data, unexpected_tlast}, exp_pulse);
      chk("frame_cnt", frame_cnt, m_fcnt);
      if (frame_start) begin
        fs_seen++;
        chk("frame_type", frame_type_o, m_type);
      end
      if (missing_data)     md_seen++;
      if (unexpected_data)  ud_seen++;
      if (unexpected_tlast) ut_seen++;
      if (prev_stall) begin
        chk("hold_vld", dout_vld, 1'b1);
        chk("hold_beat", {dout, dout_sol, dout_eol}, prev_beat);
      end
      prev_stall = dout_vld && !dout_rdy;
      prev_beat  = {dout, dout_sol, dout_eol};
      if (dout_vld && dout_rdy) begin
        if (exp_q.size() == 0) begin
          chk("extra_dout", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("dout_beat", {dout, dout_sol, dout_eol}, e);
          if (chk_lat) chk("latency", cyc - a, 2);
          if (out_cnt == watch_idx) watch_sol = dout_sol;
          out_cnt++;
        end
      end
      if (tvalid && !tready) begin
        low_run++;
      end else begin
        if (low_run > 0) chk("tready_low_run_gt2", low_run > 2, 1'b0);
        low_run = 0;
      end
      // model the beat that the coming rising edge accepts
      exp_pulse = '0;
      if (tvalid && tready) begin
        if (tuser) begin
          exp_pulse[3] = 1'b1;
          exp_pulse[2] = m_active;
          m_active = 1'b1; m_col = 0; m_line = 0; m_type = frame_type_i;
        end
        if (!m_active) begin
          exp_pulse[1] = 1'b1;
        end else begin
          sol = (m_col == 0);
          eol = (m_col == BPL - 1);
          if (tlast != eol) exp_pulse[0] = 1'b1;
          exp_q.push_back({tdata, sol, eol});
          acc_q.push_back(cyc);
          if (eol || (RESYNC && tlast)) begin
            m_col = 0;
            if (m_line == IMG_H - 1) begin
              m_active = 1'b0; m_line = 0; m_fcnt++;
            end else begin
              m_line++;
            end
          end else begin
            m_col++;
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    dout_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      dout_rdy = rdy_toggle ? ~dout_rdy : 1'b1;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [DATA_W-1:0] d, input logic u, input logic l);
    int t = 0;
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (tready) break;
      t++;
      if (t > 100) begin
        chk("drive_timeout", 1'b1, 1'b0);
        break;
      end
    end
    @(posedge clk); #1;
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  // Beats start..n-1 of a frame; tlast every BPL beats plus an optional early one
  task automatic send_frame(input int n, input int early, input int start);
    int c = 0;
    logic l;
    for (int i = 0; i < n; i++) begin
      l = (c == BPL - 1) || (i == early);
      if (i >= start) drive_beat({$urandom(), $urandom()}, i == 0, l);
      c = ((c == BPL - 1) || (RESYNC && i == early)) ? 0 : c + 1;
    end
  endtask

  // ---------------- sequence ----------------
  int s_fs, s_md, s_ud, s_ut, s_out;

  task automatic snap();
    s_fs = fs_seen; s_md = md_seen; s_ud = ud_seen; s_ut = ut_seen; s_out = out_cnt;
  endtask

  initial begin
    rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tuser = 1'b0; tlast = 1'b0; frame_type_i = 2'd0;
    wait_cycles(3);
    chk("rst_tready", tready, 1'b0);
    chk("rst_dout_vld", dout_vld, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    chk("rst_frame_type", frame_type_o, 2'd0);
    chk("rst_pulses", {frame_start, missing_data, unexpected_data, unexpected_tlast}, 4'd0);
    rst_n = 1'b1;
    wait_cycles(2);

    // stray beats before any start of frame are dropped
    snap();
    repeat (3) drive_beat({$urandom(), $urandom()}, 1'b0, 1'b0);
    wait_cycles(5);
    chk("junk_ud", ud_seen - s_ud, 3);
    chk("junk_dout", out_cnt - s_out, 0);

    // clean frame, output always ready
    snap();
    chk_lat = 1'b1; frame_type_i = 2'd2;
    send_frame(32, -1, 0);
    wait_cycles(6);
    chk_lat = 1'b0;
    chk("f1_cnt", frame_cnt, 16'd1);
    chk("f1_out", out_cnt - s_out, 32);
    chk("f1_fs", fs_seen - s_fs, 1);
    chk("f1_errs", {md_seen - s_md, ud_seen - s_ud, ut_seen - s_ut}, 96'd0);
    chk("f1_type", frame_type_o, 2'd2);
    chk("f1_idle", dbg_state, 1'b0);

    // output back-pressure every other cycle
    snap();
    rdy_toggle = 1'b1; frame_type_i = 2'd1;
    send_frame(32, -1, 0);
    wait_cycles(20);
    rdy_toggle = 1'b0;
    wait_cycles(2);
    chk("f2_cnt", frame_cnt, 16'd2);
    chk("f2_out", out_cnt - s_out, 32);

    // early tlast on beat 5 of line 1
    snap();
    frame_type_i = 2'd3; watch_idx = out_cnt + 14; watch_sol = 1'bx;
    send_frame(RESYNC ? 30 : 32, 13, 0);
    wait_cycles(6);
    chk("f3_ut", ut_seen - s_ut, 1);
    chk("f3_cnt", frame_cnt, 16'd3);
    chk("f3_sol_after_tlast", watch_sol, RESYNC);

    // start of frame arriving at beat 20
    snap();
    frame_type_i = 2'd0;
    send_frame(20, -1, 0);
    send_frame(1, -1, 0);
    wait_cycles(3);
    chk("f4_md", md_seen - s_md, 1);
    chk("f4_fs", fs_seen - s_fs, 2);
    chk("f4_cnt_hold", frame_cnt, 16'd3);
    send_frame(32, -1, 1);
    wait_cycles(6);
    chk("f4_cnt", frame_cnt, 16'd4);

    // reset in the middle of a frame
    send_frame(10, -1, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {tready, dout_vld, frame_start, unexpected_tlast, unexpected_data,
                         missing_data, dout_sol, dout_eol}, 8'd0);
    chk("mid_rst_cnt", {frame_cnt, frame_type_o, dout}, 82'd0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(1);
    chk("post_rst_idle", dbg_state, 1'b0);
    snap();
    send_frame(32, -1, 10);
    wait_cycles(5);
    chk("rest_ud", ud_seen - s_ud, 22);
    chk("rest_out", out_cnt - s_out, 0);
    chk("rest_cnt", frame_cnt, 16'd0);
    send_frame(32, -1, 0);
    wait_cycles(10);
    chk("final_cnt", frame_cnt, 16'd1);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cmlk_frame_ingress.md
CMLK_FRAME_INGRESS -- requirements
Module: cmlk_frame_ingress

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning stream data width in bits (multiple of PIX_W).
REQ-002 SHALL have parameter PIX_W, default 8, meaning bits per pixel.
REQ-003 SHALL have parameter IMG_W, default 2048, meaning pixels per line.
REQ-004 SHALL have parameter IMG_H, default 2048, meaning lines per frame.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports s_axis_cmlk_tdata in DATA_W, s_axis_cmlk_tvalid in 1, s_axis_cmlk_tready out 1, s_axis_cmlk_tlast in 1 (end of line), s_axis_cmlk_tuser in 1 (start of frame).
REQ-008 SHALL have ports dout out DATA_W, dout_vld out 1, dout_rdy in 1, dout_sol out 1 (first beat of line), dout_eol out 1 (last beat of line).
REQ-009 SHALL have ports frame_type_i in 2, frame_start out 1 (pulse), frame_type_o out 2, frame_cnt out 16 (completed frames).
REQ-010 SHALL have ports unexpected_data, unexpected_tlast and missing_data, each out 1 (one-cycle pulses).

Function
REQ-011 Derived constants SHALL be BPL = IMG_W*PIX_W/DATA_W beats per line and BPF = BPL*IMG_H beats per frame.
REQ-012 Beat acceptance SHALL be tvalid and tready in the same cycle; all counters advance on accepted beats only.
REQ-013 FSM SHALL have states IDLE (waiting for start of frame) and ACTIVE (inside a frame).
REQ-014 In IDLE, accepted beats with tuser=0 SHALL be dropped and SHALL pulse unexpected_data once per beat.
REQ-015 An accepted beat with tuser=1 in any state SHALL: enter ACTIVE, clear column/line counters, pulse frame_start one cycle later, and latch frame_type_i into frame_type_o on that same cycle.
REQ-016 When tuser=1 arrives in ACTIVE before BPF beats, missing_data SHALL pulse concurrently with frame_start, and the new frame SHALL proceed normally.
REQ-017 In ACTIVE, the column counter SHALL wrap at BPL-1 to 0 and increment the line counter; the accepted beat at line IMG_H-1, column BPL-1 SHALL increment frame_cnt (wrapping at 0xFFFF to 0) and return to IDLE.
REQ-018 unexpected_tlast SHALL pulse when tlast=1 at column != BPL-1, or tlast=0 at column BPL-1.
REQ-019 dout_sol SHALL be 1 on the column-0 output beat and dout_eol on the column-(BPL-1) output beat; both SHALL be derived from counters, never from tlast.
REQ-020 Output SHALL use a 2-entry skid buffer; tready SHALL be 1 whenever the buffer holds fewer than 2 entries, with no combinational path from dout_rdy to tready.
REQ-021 Latency SHALL be 2 cycles from accepted input beat to dout_vld when dout_rdy=1; dout/dout_sol/dout_eol SHALL hold while dout_vld=1 and dout_rdy=0.
REQ-022 Pulse outputs SHALL be registered and aligned to the cycle after the offending beat is accepted; simultaneous error conditions SHALL all assert together.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, clear all counters and skid entries, and set every output to 0, including tready, frame_type_o and frame_cnt.
REQ-024 Reset deassertion mid-frame SHALL leave the block in IDLE; the remainder of the frame SHALL be dropped per REQ-014.

Configuration
REQ-025 Macro CMLK_TLAST_RESYNC_EN defined: an early tlast SHALL force the column counter to 0 and advance the line counter, as if the line were complete.
REQ-026 Macro undefined: tlast SHALL only be flagged per REQ-018 and counting SHALL be unaffected.

Structure
REQ-027 Package cmlk_ingress_pkg SHALL hold the FSM state encoding and the BPL/BPF derivation function.
REQ-028 The skid buffer SHALL be sub-module cmlk_skid_buf (parameter W, valid/ready both sides).

Verification (DATA_W=64, PIX_W=8, IMG_W=64, IMG_H=4 -> BPL=8, BPF=32)
REQ-029 32 beats, tuser on beat 0, tlast on every 8th beat, dout_rdy=1 -> 32 dout beats, latency 2, frame_start once, frame_type_o=frame_type_i, frame_cnt=1, no error pulses.
REQ-030 Same frame with dout_rdy toggling 1/0 every cycle -> no data loss or duplication, tready never low for more than 2 cycles consecutively, dout stable while stalled.
REQ-031 tlast on beat 5 of line 1 -> unexpected_tlast pulse; with CMLK_TLAST_RESYNC_EN the next beat has dout_sol=1, without it the column continues at 6.
REQ-032 tuser reasserted at beat 20 -> missing_data and frame_start pulse together, frame_cnt unchanged; the next 32 beats complete the frame and set frame_cnt=1.
REQ-033 3 beats with tuser=0 after reset, then a valid frame -> 3 unexpected_data pulses and 0 dout beats before the frame; rst_n low at beat 10 -> outputs 0 immediately, IDLE after release.
